// File: rtl/jh_fb_pkg.sv
// Shared types and constants for the heater feedback scheduler.
package jh_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int FB_W  = 6;   // power register width
    localparam int VAL_W = 16;  // setting point / process value width
    localparam int CH_W  = 3;   // channel index width (up to 8 channels)

    localparam logic [FB_W-1:0] DEFAULT_CEIL = 6'd31;

endpackage

// File: rtl/jh_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping mod NUM_CH.
module jh_rr_arbiter
    import jh_fb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    // Scan from ptr upward; the first hit wins and later hits are masked by any.
    always_comb begin
        int k;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            if (!any && req[k]) begin
                any      = 1'b1;
                idx      = CH_W'(k);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jh_feedback_sched.sv
// Round-robin scheduler sharing one feedback-update datapath among NUM_CH heater
// channels. Holds per-channel power registers and settle hold-off counters.
// Optional feature macro: JH_FB_WATCHDOG_EN (abort a WAIT that never sees upd_done).
// ch_ovf / ch_udf are live compares on the power registers, so ch_udf reads all
// ones once the power registers have been cleared by reset.
module jh_feedback_sched
    import jh_fb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int HOLD_TICK = 7,
    parameter int WDOG_CYC  = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       ch_req,
    input  logic [VAL_W*NUM_CH-1:0] sp_bus,
    input  logic [VAL_W*NUM_CH-1:0] pv_bus,
    input  logic [FB_W-1:0]         max_power,
    input  logic                    power_unlock,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [CH_W-1:0]         upd_ch,
    output logic [VAL_W-1:0]        upd_sp,
    output logic [VAL_W-1:0]        upd_pv,
    output logic [FB_W-1:0]         upd_fb,
    input  logic                    upd_done,
    input  logic [FB_W-1:0]         upd_fb_new,
    output logic [FB_W*NUM_CH-1:0]  power_bus,
    output logic [NUM_CH-1:0]       ch_ovf,
    output logic [NUM_CH-1:0]       ch_udf,
    output logic                    busy,
    output logic                    wdog_err
);

    localparam logic [4:0] HOLD_V = 5'(HOLD_TICK);

    state_t            state;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] clr_mask;
    logic [4:0]        settle [NUM_CH];
    logic [FB_W-1:0]   power  [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   next_ptr;
    logic [FB_W-1:0]   fb_new_q;
    logic [FB_W-1:0]   ceil_val;
    logic [FB_W-1:0]   wr_val;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [VAL_W-1:0]  sel_sp;
    logic [VAL_W-1:0]  sel_pv;
    logic [FB_W-1:0]   sel_fb;
    logic              accept;
    logic              wr_en;

`ifdef JH_FB_WATCHDOG_EN
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYC - 1);
    logic [7:0] wdog_cnt;
`else
    localparam int unused_wdog_cyc = WDOG_CYC;
    assign wdog_err = 1'b0;
`endif

    // Saturate a datapath result to the active ceiling.
    function automatic logic [FB_W-1:0] fb_clamp(input logic [FB_W-1:0] v,
                                                 input logic [FB_W-1:0] c);
        return (v > c) ? c : v;
    endfunction

    assign ceil_val = power_unlock ? max_power : DEFAULT_CEIL;
    assign wr_val   = fb_clamp(fb_new_q, ceil_val);
    assign accept   = (state == ST_ISSUE) && upd_ready;
    assign wr_en    = (state == ST_WRITE);
    assign next_ptr = (upd_ch == CH_W'(NUM_CH - 1)) ? '0 : upd_ch + 1'b1;
    assign busy     = (state != ST_IDLE);

    jh_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Per-channel eligibility, accept clear mask, status flags and packed power view.
    always_comb begin
        eligible  = '0;
        clr_mask  = '0;
        ch_ovf    = '0;
        ch_udf    = '0;
        power_bus = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            eligible[k]               = pending[k] && (settle[k] == 5'd0);
            clr_mask[k]               = accept && (upd_ch == CH_W'(k));
            ch_ovf[k]                 = (power[k] == ceil_val);
            ch_udf[k]                 = (power[k] == '0);
            power_bus[k*FB_W +: FB_W] = power[k];
        end
    end

    // One-hot payload mux for the granted channel.
    always_comb begin
        sel_sp = '0;
        sel_pv = '0;
        sel_fb = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_oh[k]) begin
                sel_sp |= sp_bus[k*VAL_W +: VAL_W];
                sel_pv |= pv_bus[k*VAL_W +: VAL_W];
                sel_fb |= power[k];
            end
        end
    end

    // Pending requests: a new request in the accept cycle keeps the bit set.
    always_ff @(posedge clock) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~clr_mask) | ch_req;
    end

    // Power write-back and settle counters; a load in WRITE overrides a tick.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (reset) begin
                power[k]  <= '0;
                settle[k] <= '0;
            end else begin
                if (wr_en && (upd_ch == CH_W'(k))) power[k] <= wr_val;
                if (wr_en && (upd_ch == CH_W'(k)) && (wr_val != power[k]))
                    settle[k] <= HOLD_V;
                else if (tick && (settle[k] != 5'd0))
                    settle[k] <= settle[k] - 5'd1;
            end
        end
    end

    // Transaction FSM with registered handshake outputs and payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            upd_valid <= 1'b0;
            upd_ch    <= '0;
            upd_sp    <= '0;
            upd_pv    <= '0;
            upd_fb    <= '0;
            rr_ptr    <= '0;
            fb_new_q  <= '0;
`ifdef JH_FB_WATCHDOG_EN
            wdog_cnt  <= '0;
            wdog_err  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        state     <= ST_ISSUE;
                        upd_valid <= 1'b1;
                        upd_ch    <= gnt_idx;
                        upd_sp    <= sel_sp;
                        upd_pv    <= sel_pv;
                        upd_fb    <= sel_fb;
                    end
                end
                ST_ISSUE: begin
                    if (upd_ready) begin
                        state     <= ST_WAIT;
                        upd_valid <= 1'b0;
`ifdef JH_FB_WATCHDOG_EN
                        wdog_cnt  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (upd_done) begin
                        state    <= ST_WRITE;
                        fb_new_q <= upd_fb_new;
                    end
`ifdef JH_FB_WATCHDOG_EN
                    else if (wdog_cnt == WDOG_LAST) begin
                        state    <= ST_IDLE;
                        wdog_err <= 1'b1;
                        rr_ptr   <= next_ptr;
                    end else begin
                        wdog_cnt <= wdog_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_ptr;
                end
            endcase
        end
    end

endmodule
